// File: rtl/adder4_checker.sv
// Exhaustive self-test sequencer for an external 4-bit adder: sweeps all 512
// {a,b,carryin} vectors, compares {carryout,sum} and reports error statistics.
module adder4_checker #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic       carryin,
  input  logic [3:0] sum,
  input  logic       carryout,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [9:0] err_count,
  output logic       first_fail_valid,
  output logic [8:0] first_fail_vec
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [3:0] HOLD_INIT = 4'(SETTLE - 1);

  state_t     state;
  logic [8:0] v;
  logic [3:0] hold;
  logic [4:0] golden;
  logic       mismatch;

  assign golden   = {1'b0, a} + {1'b0, b} + {4'b0000, carryin};
  assign mismatch = ({carryout, sum} != golden);

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      v                <= '0;
      hold             <= '0;
      a                <= '0;
      b                <= '0;
      carryin          <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= '0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state            <= RUN;
            v                <= '0;
            hold             <= HOLD_INIT;
            a                <= '0;
            b                <= '0;
            carryin          <= 1'b0;
            busy             <= 1'b1;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
          end
        end
        RUN: begin
          if (hold != 4'd0) begin
            hold <= hold - 4'd1;
          end else begin
            if (mismatch) begin
              err_count <= err_count + 10'd1;
              if (!first_fail_valid) begin
                first_fail_valid <= 1'b1;
                first_fail_vec   <= v;
              end
            end
            // pass must reflect the final vector's compare, not just the running count
            if (v == 9'd511) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_count == 10'd0) && !mismatch;
            end else begin
              v                  <= v + 9'd1;
              {a, b, carryin}    <= v + 9'd1;
              hold               <= HOLD_INIT;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/adder4_checker.md
ADDER4_CHECKER -- requirements
Module: adder4_checker

Interface
REQ-001 Parameter: SETTLE, default 1, cycles each vector is held before its compare; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to begin an exhaustive sweep.
REQ-005 a  output  4  registered operand A driven to the 4-bit adder under test.
REQ-006 b  output  4  registered operand B driven to the adder under test.
REQ-007 carryin  output  1  registered carry-in driven to the adder under test.
REQ-008 sum  input  4  adder result returned from the adder under test (combinational path).
REQ-009 carryout  input  1  adder carry-out returned from the adder under test.
REQ-010 busy  output  1  high while a sweep is in progress.
REQ-011 done  output  1  high from sweep completion until the next accepted start or reset.
REQ-012 pass  output  1  high with done when err_count is 0; low otherwise.
REQ-013 err_count  output  10  number of mismatching vectors in the current or last sweep.
REQ-014 first_fail_valid  output  1  high once any mismatch has been recorded in the sweep.
REQ-015 first_fail_vec  output  9  vector index of the first mismatch; 0 while first_fail_valid is low.

Function
REQ-016 The block SHALL implement states IDLE, RUN, DONE.
REQ-017 Vector index v is 9 bits; the encoding SHALL be a=v[8:5], b=v[4:1], carryin=v[0]; v sweeps 0..511 ascending, no skips.
REQ-018 IDLE: start=1 at an edge SHALL clear err_count, first_fail_valid, first_fail_vec, set v=0, drive a/b/carryin from v=0, go to RUN; busy=1 from the next cycle.
REQ-019 RUN: each vector SHALL be held exactly SETTLE cycles, tracked by a 4-bit hold counter that reloads on every vector change.
REQ-020 In the last hold cycle of a vector, the block SHALL compare {carryout,sum} against the 5-bit golden value a+b+carryin, all operands zero-extended to 5 bits.
REQ-021 On mismatch, err_count SHALL increment at that edge; if first_fail_valid is 0, first_fail_vec SHALL load v and first_fail_valid SHALL set.
REQ-022 After the compare of v=511, the next edge SHALL enter DONE: busy=0, done=1, pass=(final err_count==0); v does not wrap.
REQ-023 With SETTLE=1, done SHALL rise exactly 512 edges after the start-accepting edge; in general 512*SETTLE edges.
REQ-024 start while in RUN SHALL be ignored; the sweep continues unperturbed.
REQ-025 start while in DONE SHALL behave as in IDLE (clear results, restart at v=0, done drops on that edge).
REQ-026 err_count cannot exceed 512 and SHALL NOT wrap; no saturation logic is required.
REQ-027 a/b/carryin SHALL hold the last driven vector in DONE; results SHALL hold stable until restart or reset.
REQ-028 done and busy SHALL never be high in the same cycle.

Reset
REQ-029 reset=1 at an edge SHALL force IDLE, and set a=0, b=0, carryin=0, busy=0, done=0, pass=0, err_count=0, first_fail_valid=0, first_fail_vec=0, v=0, hold counter=0.
REQ-030 reset SHALL take priority over start and over an in-progress compare in the same cycle.
REQ-031 reset mid-RUN SHALL abandon the sweep; no partial result remains visible.

Verification
REQ-032 Correct adder, SETTLE=1, start pulse -> done at edge +512, pass=1, err_count=0, first_fail_valid=0.
REQ-033 Adder with sum[0] stuck at 0 -> err_count=256, pass=0, first_fail_vec=1 (a=0,b=0,carryin=1).
REQ-034 Adder with carryout stuck at 0 -> err_count=256, first_fail_vec=31 (a=0,b=15,carryin=1).
REQ-035 SETTLE=3, adder with one registered stage -> pass=1 at edge +1536; same adder with SETTLE=1 -> pass=0.
REQ-036 reset asserted at v=200, then start -> outputs zero after reset; new sweep begins at v=0 with err_count 0.
REQ-037 start pulsed at v=100 during RUN and again in DONE -> first ignored (done still at +512); second clears results and restarts at v=0.
